// File: rtl/if_stage_if.sv
// if_stage_if: fetch-stage control, ROM and IF/ID latch signals
interface if_stage_if;
  logic        stall_if;
  logic        stall_id;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  modport master (
    output stall_if, stall_id, flush, new_pc, branch_flag, branch_target, rom_inst,
    input  rom_ce, rom_addr, id_pc, id_inst, id_valid
  );
  modport slave (
    input  stall_if, stall_id, flush, new_pc, branch_flag, branch_target, rom_inst,
    output rom_ce, rom_addr, id_pc, id_inst, id_valid
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: MIPS fetch stage (PC, ROM drive, IF/ID latch); IF_BRANCH_DELAY_SLOT_EN keeps the delay slot
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic clk,
  input logic rst,
  if_stage_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]  ce_q;
  logic        run;
  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic        pend_valid;
  logic [31:0] tgt;
  logic [31:0] npc;
  logic        squash;
  logic [31:0] id_pc_q;
  logic [31:0] id_inst_q;
  logic        id_valid_q;
  assign run = ce_q == RUN;
  assign tgt = bus.branch_target & ~32'h3;
  assign npc = bus.new_pc & ~32'h3;
  assign bus.rom_ce = ce_q[0];
  assign bus.rom_addr = pc;
  assign bus.id_pc = id_pc_q;
  assign bus.id_inst = id_inst_q;
  assign bus.id_valid = id_valid_q;
`ifdef IF_BRANCH_DELAY_SLOT_EN
  assign squash = 1'b0;
`else
  logic pend_squash;
  assign squash = bus.branch_flag || (pend_valid && pend_squash);
  // Remember that the slot held behind a parked branch must be dropped when the target is taken
  always_ff @(posedge clk or posedge rst)
    if (rst) pend_squash <= 1'b0;
    else if (!run || bus.flush || (!bus.stall_if && (bus.branch_flag || pend_valid))) pend_squash <= 1'b0;
    else if (bus.stall_if && bus.branch_flag) pend_squash <= 1'b1;
`endif
  // Chip enable: IDLE until the first edge after reset, then RUN until the next reset
  always_ff @(posedge clk or posedge rst)
    if (rst) ce_q <= IDLE;
    else ce_q <= RUN;
  // PC and parked branch target: flush > stall > branch > parked target > sequential
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= RESET_PC;
      pend_pc <= 32'h0;
      pend_valid <= 1'b0;
    end else if (!run) begin
      pc <= RESET_PC;
      pend_valid <= 1'b0;
    end else if (bus.flush) begin
      pc <= npc;
      pend_valid <= 1'b0;
    end else if (bus.stall_if) begin
      if (bus.branch_flag) begin
        pend_pc <= tgt;
        pend_valid <= 1'b1;
      end
    end else if (bus.branch_flag) begin
      pc <= tgt;
      pend_valid <= 1'b0;
    end else if (pend_valid) begin
      pc <= pend_pc;
      pend_valid <= 1'b0;
    end else begin
      pc <= pc + 32'd4;
    end
  // IF/ID latch: bubble when idle, flushed, fetch stalled or slot squashed; hold on stall_id
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      id_pc_q <= 32'h0;
      id_inst_q <= 32'h0;
      id_valid_q <= 1'b0;
    end else if (!run || bus.flush || (!bus.stall_id && (bus.stall_if || squash))) begin
      id_pc_q <= 32'h0;
      id_inst_q <= 32'h0;
      id_valid_q <= 1'b0;
    end else if (!bus.stall_id) begin
      id_pc_q <= pc;
      id_inst_q <= bus.rom_inst;
      id_valid_q <= 1'b1;
    end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline. Owns the program counter, drives the chip-enable and address of the combinational instruction ROM, and registers the returned word with its PC into the IF/ID pipeline latch for decode. Handles stalls, exception flushes and branch redirects, including branches that resolve while fetch is stalled. The architectural branch delay slot is compile-time selectable.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `stall_if`  in  1  hold PC and the ROM address.
- `stall_id`  in  1  hold the IF/ID latch.
- `flush`  in  1  exception/eret redirect.
- `new_pc`  in  32  redirect address for `flush`.
- `branch_flag`  in  1  taken branch/jump resolved in ID.
- `branch_target`  in  32  branch destination.
- `rom_ce`  out  1  ROM chip enable (1 = enabled).
- `rom_addr`  out  32  byte fetch address; equals the PC register.
- `rom_inst`  in  32  ROM word, combinational from `rom_addr`.
- `id_pc`  out  32  registered PC of the instruction in ID.
- `id_inst`  out  32  registered instruction for ID.
- `id_valid`  out  1  `id_inst` is a real fetch, not a bubble.

## Operation
- State: `pc`, `ce_q`, `pend_valid`, `pend_pc`, and (macro off only) `pend_squash`.
- `ce_q` is a 2-state FSM with states IDLE (0) and RUN (1). IDLE goes to RUN on the first edge after `rst` falls. RUN returns to IDLE only on `rst`. `rom_ce = ce_q`.
- `new_pc` and `branch_target` bits [1:0] are forced to 0.
- PC update rules, in priority order:
  - IDLE: `pc = RESET_PC`.
  - `flush`: `pc = new_pc`; clear pending state.
  - `stall_if`: hold `pc`. If `branch_flag` is high, set `pend_pc = branch_target` and `pend_valid = 1`. A later branch during the same stall overwrites it.
  - `branch_flag`: `pc = branch_target`.
  - `pend_valid`: `pc = pend_pc`; clear `pend_valid`.
  - Otherwise: `pc = pc + 4`, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- IF/ID latch rules, in priority order:
  - `flush`: bubble.
  - `stall_id`: hold.
  - `stall_if`: bubble.
  - Otherwise capture `{pc, rom_inst, 1}`.
  - A bubble is `id_pc = 0`, `id_inst = 0`, `id_valid = 0`.
  - While in IDLE, capture is a bubble.

## Timing
- Reset values: `rom_ce = 0`, `rom_addr = RESET_PC`, `id_pc = 0`, `id_inst = 0`, `id_valid = 0`, all pending state cleared.
- Let T0 be the first edge after `rst` deasserts.
- `rom_ce` rises at T0. `rom_addr = RESET_PC` during the cycle after T0. That instruction appears on `id_*` after T0+1.
- Fetch-to-ID latency is 1 cycle. Steady-state throughput is 1 instruction per cycle.
- A redirect (`flush`, `branch_flag`, or pending) changes `rom_addr` one edge after it is sampled.
- `rst` asserted mid-operation clears everything immediately (asynchronous). Any pending branch is lost.
- `flush` together with `stall_if` or `stall_id`: `flush` wins, and both PC and latch redirect/bubble.

## Configuration
- Macro `IF_BRANCH_DELAY_SLOT_EN`.
- Defined (MIPS-compliant):
  - The instruction in IF when `branch_flag` is sampled is the delay slot and enters ID normally.
  - A pending target is applied after the held delay slot is captured.
- Undefined:
  - On an unstalled `branch_flag`, the latch captures a bubble instead of `rom_inst`.
  - On a branch captured into pending, set `pend_squash`. The capture at the edge where the pending target is applied becomes a bubble, and `pend_squash` clears.

## Test plan
- Reset release with `RESET_PC` = 32'hBFC0_0000 and no stalls:
  - `rom_ce` goes 0→1 at T0.
  - `id_pc` is BFC0_0000, BFC0_0004, BFC0_0008 on consecutive cycles from T0+1, with `id_valid = 1`.
- `stall_if = stall_id = 1` for 3 cycles at `pc` = 0x10:
  - `rom_addr` holds 0x10 and `id_*` holds its value.
  - After release, 0x10 then 0x14 reach ID with no duplicates or gaps.
- `stall_if = 1`, `stall_id = 0` for 2 cycles: two bubbles (`id_valid = 0`, `id_inst = 0`), then fetch resumes.
- `branch_flag` with target 0x2003 while `pc` = 0x40:
  - Macro on: ID sees 0x40 (the delay slot), then 0x2000.
  - Macro off: ID sees a bubble, then 0x2000.
  - In both cases `rom_addr` = 0x2000 on the next cycle.
- `branch_flag` (target 0x300) during a 2-cycle `stall_if`:
  - After release, `rom_addr` = 0x300 one cycle after the held instruction is captured (macro on), or with that capture bubbled (macro off).
- `flush` with `new_pc` = 0x180 asserted together with `stall_if`, `stall_id` and a pending branch:
  - Next `rom_addr` = 0x180, ID gets a bubble, pending is discarded.
- Async `rst` pulse mid-cycle: outputs return to reset values immediately.
